// File: rtl/hid_log_pkg.sv
// Shared types and ASCII helpers for the HID report logger.
package hid_log_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TYPE = 3'd1,
    ST_SEP  = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_CR   = 3'd5,
    ST_LF   = 3'd6
  } log_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_N  = 8'h4E;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_G  = 8'h47;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] ch;
    if (nibble < 4'd10) begin
      ch = 8'h30 + {4'h0, nibble};
    end else begin
      ch = 8'h37 + {4'h0, nibble};
    end
    return ch;
  endfunction

  function automatic logic [7:0] type_char(input logic [1:0] typ);
    logic [7:0] ch;
    case (typ)
      2'd0:    ch = ASCII_N;
      2'd1:    ch = ASCII_K;
      2'd2:    ch = ASCII_M;
      2'd3:    ch = ASCII_G;
      default: ch = ASCII_N;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter; ready also rises in the last stop-bit cycle so
// characters can be chained without an idle gap.
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          active_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    bit_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          bit_end_s;
  logic          last_s;

  // bit_r: 0 = start bit, 1..8 = data bits, 9 = stop bit
  assign bit_end_s = (cnt_r == CNT_LAST);
  assign last_s    = active_r && bit_end_s && (bit_r == 4'd9);
  assign ready     = !active_r || last_s;
  assign tx        = tx_r;

  // Frame sequencer and serial output register
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      bit_r    <= 4'd0;
      shift_r  <= 8'h00;
      tx_r     <= 1'b1;
    end else if (start && ready) begin
      active_r <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      bit_r    <= 4'd0;
      shift_r  <= data;
      tx_r     <= 1'b0;
    end else if (active_r) begin
      if (bit_end_s) begin
        cnt_r <= {CW{1'b0}};
        if (bit_r == 4'd9) begin
          active_r <= 1'b0;
          tx_r     <= 1'b1;
        end else begin
          bit_r <= bit_r + 4'd1;
          if (bit_r == 4'd8) begin
            tx_r <= 1'b1;
          end else begin
            tx_r    <= shift_r[0];
            shift_r <= {1'b0, shift_r[7:1]};
          end
        end
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/hid_report_logger.sv
// Queues HID reports and prints each as an ASCII hex line over UART 8N1.
// Define HID_LOG_DEDUP_EN to discard reports identical to the last accepted one.
module hid_report_logger
  import hid_log_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int BAUD         = 115_200,
  parameter int REPORT_BYTES = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            report_valid,
  input  logic [1:0]                      report_typ,
  input  logic [8*REPORT_BYTES-1:0]       report_data,
  output logic                            uart_tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [7:0]                      drop_cnt,
  output logic [7:0]                      dup_cnt
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (REPORT_BYTES > 1) ? $clog2(REPORT_BYTES) : 1;
  localparam int DW = 8 * REPORT_BYTES;
  localparam logic [BW-1:0] LAST_IDX = BW'(REPORT_BYTES - 1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);

  logic [1:0]    fifo_typ_r  [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]   wr_nxt_s, rd_nxt_s;
  logic [LW-1:0] level_r, level_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic [7:0]    drop_r;
  logic [7:0]    dup_r;

  log_state_t    state_r;
  logic [1:0]    line_typ_r;
  logic [DW-1:0] line_data_r;
  logic [BW-1:0] byte_idx_r;
  logic [DW-1:0] line_shift_s;
  logic [7:0]    cur_byte_s;
  logic [7:0]    char_s;

  logic empty_s, full_s, pop_s, push_s, drop_s, dup_s;
  logic start_s, ready_s, hs_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = (state_r == ST_IDLE) && !empty_s;
  // A full FIFO still takes a strobe when the same cycle frees a slot
  assign push_s  = report_valid && !dup_s && (!full_s || pop_s);
  assign drop_s  = report_valid && !dup_s && !push_s;

  assign wr_nxt_s    = wr_ptr_r + {{AW{1'b0}}, push_s};
  assign rd_nxt_s    = rd_ptr_r + {{AW{1'b0}}, pop_s};
  assign level_nxt_s = wr_nxt_s - rd_nxt_s;

  assign start_s = (state_r != ST_IDLE);
  assign hs_s    = start_s && ready_s;

  assign busy_nxt_s = pop_s || (level_nxt_s != {LW{1'b0}}) ||
                      (start_s && !((state_r == ST_LF) && hs_s));

`ifdef HID_LOG_DEDUP_EN
  logic          last_valid_r;
  logic [1:0]    last_typ_r;
  logic [DW-1:0] last_data_r;

  assign dup_s = report_valid && last_valid_r &&
                 (report_typ == last_typ_r) && (report_data == last_data_r);

  // Remember the most recently accepted report for duplicate filtering
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid_r <= 1'b0;
      last_typ_r   <= 2'd0;
      last_data_r  <= {DW{1'b0}};
    end else if (push_s) begin
      last_valid_r <= 1'b1;
      last_typ_r   <= report_typ;
      last_data_r  <= report_data;
    end
  end

  // Saturating duplicate counter
  always_ff @(posedge clk) begin
    if (rst) begin
      dup_r <= 8'h00;
    end else if (dup_s && (dup_r != 8'hFF)) begin
      dup_r <= dup_r + 8'd1;
    end
  end
`else
  assign dup_s = 1'b0;
  assign dup_r = 8'h00;
`endif

  // FIFO storage; emptiness is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_typ_r[wr_ptr_r[AW-1:0]]  <= report_typ;
      fifo_data_r[wr_ptr_r[AW-1:0]] <= report_data;
    end
  end

  // Pointers, status outputs and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      level_r  <= {LW{1'b0}};
      busy_r   <= 1'b0;
      drop_r   <= 8'h00;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      level_r  <= level_nxt_s;
      busy_r   <= busy_nxt_s;
      if (drop_s && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end
    end
  end

  assign line_shift_s = line_data_r >> {byte_idx_r, 3'b000};
  assign cur_byte_s   = line_shift_s[7:0];

  // Character presented to the UART for the current state
  always_comb begin
    char_s = 8'h00;
    case (state_r)
      ST_TYPE: char_s = type_char(line_typ_r);
      ST_SEP:  char_s = ASCII_SP;
      ST_HI:   char_s = hex_ascii(cur_byte_s[7:4]);
      ST_LO:   char_s = hex_ascii(cur_byte_s[3:0]);
      ST_CR:   char_s = ASCII_CR;
      ST_LF:   char_s = ASCII_LF;
      default: char_s = 8'h00;
    endcase
  end

  // Line sequencer: one UART character per non-idle state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      line_typ_r  <= 2'd0;
      line_data_r <= {DW{1'b0}};
      byte_idx_r  <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            line_typ_r  <= fifo_typ_r[rd_ptr_r[AW-1:0]];
            line_data_r <= fifo_data_r[rd_ptr_r[AW-1:0]];
            byte_idx_r  <= {BW{1'b0}};
            state_r     <= ST_TYPE;
          end
        end
        ST_TYPE: if (hs_s) state_r <= ST_SEP;
        ST_SEP:  if (hs_s) state_r <= ST_HI;
        ST_HI:   if (hs_s) state_r <= ST_LO;
        ST_LO: begin
          if (hs_s) begin
            if (byte_idx_r == LAST_IDX) begin
              state_r <= ST_CR;
            end else begin
              byte_idx_r <= byte_idx_r + IDX_ONE;
              state_r    <= ST_SEP;
            end
          end
        end
        ST_CR:   if (hs_s) state_r <= ST_LF;
        ST_LF:   if (hs_s) state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .data  (char_s),
    .ready (ready_s),
    .tx    (uart_tx)
  );

  assign busy       = busy_r;
  assign fifo_level = level_r;
  assign drop_cnt   = drop_r;
  assign dup_cnt    = dup_r;

endmodule

// File: tb/tb_hid_report_logger.sv
// Directed bench: an 8-byte logger (8 clocks/bit) and a 1-byte logger (4 clocks/bit),
// each observed through a UART receiver model.
module tb_hid_report_logger;

  localparam int CPB_A = 12_000_000 / 1_500_000;
  localparam int CPB_B = 12_000_000 / 3_000_000;

  logic clk;
  logic rst;

  logic        valid_a, tx_a, busy_a;
  logic [1:0]  typ_a;
  logic [63:0] data_a;
  logic [2:0]  level_a;
  logic [7:0]  drop_a, dup_a;

  logic        valid_b, tx_b, busy_b;
  logic [1:0]  typ_b;
  logic [7:0]  data_b;
  logic [1:0]  level_b;
  logic [7:0]  drop_b, dup_b;

  int n_checks = 0;
  int n_pass   = 0;
  int frame_err_a = 0;
  int frame_err_b = 0;
  int starts_a = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  hid_report_logger #(
    .CLK_HZ(12_000_000), .BAUD(1_500_000), .REPORT_BYTES(8), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .report_valid(valid_a), .report_typ(typ_a),
    .report_data(data_a), .uart_tx(tx_a), .busy(busy_a),
    .fifo_level(level_a), .drop_cnt(drop_a), .dup_cnt(dup_a)
  );

  hid_report_logger #(
    .CLK_HZ(12_000_000), .BAUD(3_000_000), .REPORT_BYTES(1), .FIFO_DEPTH(2)
  ) dut_b (
    .clk(clk), .rst(rst), .report_valid(valid_b), .report_typ(typ_b),
    .report_data(data_b), .uart_tx(tx_b), .busy(busy_b),
    .fifo_level(level_b), .drop_cnt(drop_b), .dup_cnt(dup_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART receiver model for dut_a: mid-bit sampling on the falling clock edge
  initial begin : mon_a
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_a == 1'b0) begin
        starts_a++;
        repeat (CPB_A / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB_A) @(negedge clk);
          b[k] = tx_a;
        end
        repeat (CPB_A) @(negedge clk);
        if (tx_a != 1'b1) frame_err_a++;
        q_a.push_back(b);
      end
    end
  end

  // UART receiver model for dut_b
  initial begin : mon_b
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_b == 1'b0) begin
        repeat (CPB_B / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB_B) @(negedge clk);
          b[k] = tx_b;
        end
        repeat (CPB_B) @(negedge clk);
        if (tx_b != 1'b1) frame_err_b++;
        q_b.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    if (sel == 0) return q_a.size();
    return q_b.size();
  endfunction

  task automatic strobe_a(input logic [1:0] t, input logic [63:0] d);
    valid_a = 1'b1; typ_a = t; data_a = d;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [1:0] t, input logic [7:0] d);
    valid_b = 1'b1; typ_b = t; data_b = d;
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  // Build the expected ASCII line and compare it character by character
  task automatic expect_line(input int sel, input string tag, input logic [1:0] typ,
                             input logic [63:0] data, input int nb);
    string hx = "0123456789ABCDEF";
    string tc = "NKMG";
    logic [7:0] e[$];
    logic [7:0] b, c;
    int waited = 0;
    e.push_back(8'(tc.getc(int'(typ))));
    for (int i = 0; i < nb; i++) begin
      b = data[8*i +: 8];
      e.push_back(8'h20);
      e.push_back(8'(hx.getc(int'(b[7:4]))));
      e.push_back(8'(hx.getc(int'(b[3:0]))));
    end
    e.push_back(8'h0D);
    e.push_back(8'h0A);
    while (qsize(sel) < e.size() && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_arrived"}, 64'(qsize(sel) >= e.size()), 64'd1);
    if (qsize(sel) >= e.size()) begin
      for (int i = 0; i < e.size(); i++) begin
        if (sel == 0) c = q_a.pop_front();
        else          c = q_b.pop_front();
        check($sformatf("%s_ch%0d", tag, i), c, e[i]);
      end
    end
  endtask

  logic [63:0] d2 [5] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                          64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                          64'hA5A5_5A5A_0F0F_F0F0};
  logic [1:0]  t2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [63:0] d3 [5] = '{64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
                          64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004,
                          64'h5000_0000_0000_0005};

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, m, base;
    logic [63:0] m1, m2;
    rst = 1'b1;
    valid_a = 1'b0; typ_a = 2'd0; data_a = 64'd0;
    valid_b = 1'b0; typ_b = 2'd0; data_b = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_lvl_a", level_a, 0);
    check("rst_drop_a", drop_a, 0);
    check("rst_dup_a", dup_a, 0);
    check("rst_tx_b", tx_b, 1);
    check("rst_busy_b", busy_b, 0);

    // Test 1: latency, bit time and line content
    strobe_a(2'd1, 64'h0000_0000_0004_0002);
    check("t1_tx_e0", tx_a, 1);
    check("t1_lvl_e0", level_a, 1);
    check("t1_busy_e0", busy_a, 1);
    @(negedge clk);
    check("t1_tx_e1", tx_a, 1);
    check("t1_lvl_e1", level_a, 0);
    @(negedge clk);
    check("t1_tx_e2", tx_a, 0);
    n = 0;
    while (tx_a == 1'b0 && n < 1000) begin n++; @(negedge clk); end
    check("t1_start_len", n, CPB_A);
    m = 0;
    while (tx_a == 1'b1 && m < 1000) begin m++; @(negedge clk); end
    check("t1_b01_len", m, 2 * CPB_A);
    expect_line(0, "t1", 2'd1, 64'h0000_0000_0004_0002, 8);
    repeat (2 * CPB_A) @(negedge clk);
    check("t1_idle_busy", busy_a, 0);
    check("t1_idle_tx", tx_a, 1);

    // Test 2: four queued behind the one in flight, sixth dropped
    for (int i = 0; i < 5; i++) strobe_a(t2[i], d2[i]);
    check("t2_lvl", level_a, 4);
    check("t2_drop0", drop_a, 0);
    check("t2_busy", busy_a, 1);
    repeat (20) @(negedge clk);
    strobe_a(2'd2, 64'hDEAD_BEEF_0000_0001);
    check("t2_drop1", drop_a, 1);
    check("t2_lvl_full", level_a, 4);
    for (int i = 0; i < 5; i++) expect_line(0, $sformatf("t2_l%0d", i), t2[i], d2[i], 8);
    repeat (2 * CPB_A) @(negedge clk);
    check("t2_end_busy", busy_a, 0);
    check("t2_end_lvl", level_a, 0);

    // Test 3: strobe on the pop cycle while full
    for (int i = 0; i < 5; i++) strobe_a(2'd3, d3[i]);
    #1;
    base = starts_a;
    n = 0;
    while (starts_a < base + 26 && n < 20000) begin @(negedge clk); #1; n++; end
    check("t3_lf_seen", starts_a - base, 26);
    check("t3_lvl_before", level_a, 4);
    strobe_a(2'd0, 64'h7777_0000_1234_ABCD);
    check("t3_lvl_after", level_a, 4);
    check("t3_drop", drop_a, 1);
    for (int i = 0; i < 5; i++) expect_line(0, $sformatf("t3_l%0d", i), 2'd3, d3[i], 8);
    expect_line(0, "t3_l5", 2'd0, 64'h7777_0000_1234_ABCD, 8);
    repeat (2 * CPB_A) @(negedge clk);

    // Test 4: reset mid-character
    strobe_a(2'd1, 64'h0101_0101_0101_0101);
    strobe_a(2'd2, 64'h0202_0202_0202_0202);
    strobe_a(2'd3, 64'h0303_0303_0303_0303);
    repeat (3 * CPB_A + 3) @(negedge clk);
    check("t4_busy_pre", busy_a, 1);
    check("t4_lvl_pre", level_a, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_tx", tx_a, 1);
    check("t4_busy", busy_a, 0);
    check("t4_lvl", level_a, 0);
    check("t4_drop", drop_a, 0);
    check("t4_dup", dup_a, 0);
    repeat (12 * CPB_A) @(negedge clk);
    q_a.delete();
    strobe_a(2'd1, 64'h0011_2233_4455_6677);
    expect_line(0, "t4", 2'd1, 64'h0011_2233_4455_6677, 8);
    repeat (2 * CPB_A) @(negedge clk);

    // Test 5: repeated mouse report
    m1 = 64'h0000_0000_0010_FF01;
    m2 = 64'h0000_0000_0011_FF01;
    for (int k = 0; k < 3; k++) begin strobe_a(2'd2, m1); @(negedge clk); end
    strobe_a(2'd2, m2);
    check("t5_drop", drop_a, 0);
`ifdef HID_LOG_DEDUP_EN
    check("t5_dup", dup_a, 2);
    expect_line(0, "t5_l0", 2'd2, m1, 8);
    expect_line(0, "t5_l1", 2'd2, m2, 8);
`else
    check("t5_dup", dup_a, 0);
    for (int k = 0; k < 3; k++) expect_line(0, $sformatf("t5_l%0d", k), 2'd2, m1, 8);
    expect_line(0, "t5_l3", 2'd2, m2, 8);
`endif
    repeat (30 * CPB_A) @(negedge clk);
    check("t5_no_extra", q_a.size(), 0);
    check("t5_busy", busy_a, 0);

    // Test 6: single-byte line and drop counter saturation
    strobe_b(2'd0, 8'hAF);
    expect_line(1, "t6", 2'd0, 64'h0000_0000_0000_00AF, 1);
    repeat (3 * CPB_B) @(negedge clk);
    check("t6_len", q_b.size(), 0);
    for (int i = 0; i < 300; i++) strobe_b(2'(i % 4), 8'(i));
    check("t6_drop_sat", drop_b, 255);
    check("t6_busy", busy_b, 1);

    check("frame_err_a", frame_err_a, 0);
    check("frame_err_b", frame_err_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
